inst_fetch: RTL
===============

# inst_fetch

Instruction fetch stage of the CPU32 pipeline. It owns the program counter and drives the word address to the combinational instruction ROM. It captures the returned instruction into the IF/ID pipeline register consumed by decode. It also accepts stall and branch/jump redirect requests from later stages, and halts on a misaligned redirect target.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word-aligned.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- stall, input, 1: hold PC and IF/ID register this cycle.
- redirect, input, 1: taken branch/jump request.
- redirect_pc, input, 32: target of redirect.
- imem_pc, output, 32: fetch address to instruction ROM; equals PC register.
- imem_inst, input, 32: instruction word returned combinationally for imem_pc.
- id_inst, output, 32: IF/ID instruction.
- id_pc, output, 32: address of id_inst.
- id_pc_plus4, output, 32: id_pc + 4 (link value for jal/jalr/bltzal).
- id_valid, output, 1: id_inst is a real instruction; 0 = bubble.
- fetch_fault, output, 1: sticky misaligned-redirect flag.

## Operation

- State machine: BOOT, RUN, FAULT.
  - BOOT: entered on reset, lasts exactly one cycle. The IF/ID register is loaded normally, then the machine goes to RUN.
  - RUN: normal fetch.
  - FAULT: entered when an accepted redirect has redirect_pc[1:0] != 0. Exit only by reset.
- Reset (async assert, any state):
  - PC = RESET_PC
  - id_inst = 32'h0
  - id_pc = 0
  - id_pc_plus4 = 0
  - id_valid = 0
  - fetch_fault = 0
  - state = BOOT
- Each non-stalled cycle in BOOT/RUN:
  - id_inst <= imem_inst
  - id_pc <= PC
  - id_pc_plus4 <= PC + 4
  - id_valid <= 1
  - PC <= next PC
- Next PC is redirect_pc if redirect=1, else PC + 4.
- Arithmetic: PC + 4 is 32-bit modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0. No carry out.
- Priority: stall over redirect. While stall=1, PC, IF/ID and state are held, and redirect is ignored. The requester holds redirect/redirect_pc until a cycle with stall=0.
- Redirect accepted with the target aligned: PC <= redirect_pc. IF/ID behaviour is set by the Configuration macro.
- Redirect accepted with the target misaligned:
  - PC holds.
  - IF/ID gets a bubble: id_inst=0, id_valid=0.
  - fetch_fault <= 1, state <= FAULT.
- FAULT:
  - PC frozen.
  - id_valid=0 and id_inst=0 every cycle.
  - stall and redirect ignored.
- Deassertion of rst_n is assumed synchronised externally; the first rising edge after deassertion is the BOOT cycle.

## Timing

- imem_pc is combinational from the PC register. Fetch-to-IF/ID latency is 1 cycle.
- Redirect asserted in cycle N (no stall): imem_pc = redirect_pc in cycle N+1, and the target appears on id_inst in cycle N+2.
- Stall: outputs unchanged on the edge ending a stalled cycle. Stall has no limit on length.
- Reset mid-operation clears everything asynchronously, including FAULT. No partial instruction survives.

## Configuration

- FETCH_DELAY_SLOT_EN defined (MIPS delay slot):
  - On an accepted aligned redirect, the instruction fetched in that cycle (at PC, the delay slot) is captured with id_valid=1.
  - The program supplies a nop or useful instruction in the slot.
- Not defined:
  - On an accepted aligned redirect, the IF/ID register is loaded with a bubble (id_inst=0, id_valid=0). The slot instruction is squashed.
  - id_pc and id_pc_plus4 still load PC and PC+4 so that debug tracing stays consistent.

## Test plan

- Reset then 4 free-running cycles, RESET_PC=0, ROM returns 32'h2008ffff at address 0:
  - During reset: id_valid=0, imem_pc=0.
  - After the first edge: id_inst=32'h2008ffff, id_pc=0, id_pc_plus4=4, id_valid=1.
  - imem_pc steps 4, 8, 12.
- Stall held 3 cycles at PC=0x10 with redirect=1 to 0x100 asserted during the stall:
  - PC, id_* unchanged for all 3 cycles.
  - Redirect is taken on the first unstalled cycle; imem_pc=0x100 in the following cycle.
- Redirect to 0x2E8 while fetching 0x2EC:
  - With FETCH_DELAY_SLOT_EN: id_pc=0x2EC with id_valid=1, then id_pc=0x2E8.
  - Without: id_valid=0 for one cycle, then id_pc=0x2E8 with id_valid=1.
- Redirect to 0x2EA:
  - fetch_fault=1 and id_valid=0 from the next cycle; imem_pc frozen.
  - A further redirect to 0x300 has no effect.
  - Pulsing rst_n low clears the fault, and imem_pc=RESET_PC.
- Redirect to 32'hFFFF_FFFC then run 2 cycles:
  - id_pc=FFFF_FFFC, id_pc_plus4=0.
  - imem_pc wraps to 0, and the next id_pc=0.
- Assert rst_n low asynchronously mid-cycle during RUN at PC=0x40:
  - Outputs reach reset values before the next clock edge.
  - After release, the first captured instruction is at RESET_PC.

Source files
------------

// File: rtl/inst_fetch.sv
// CPU32 instruction fetch stage: owns the PC, drives the instruction ROM and the IF/ID register.
// Optional MIPS delay slot on taken redirects via `define FETCH_DELAY_SLOT_EN.
//
// state | meaning
// BOOT  | first cycle after reset, IF/ID loads normally
// RUN   | normal sequential fetch / redirect handling
// FAULT | misaligned redirect seen; PC frozen, bubbles only, exit by reset
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_inst,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misaligned;

  assign pc_plus4   = pc + 32'd4;
  assign imem_pc    = pc;
  assign misaligned = redirect && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      id_inst     <= 32'h0;
      id_pc       <= 32'h0;
      id_pc_plus4 <= 32'h0;
      id_valid    <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      case (state)
        BOOT, RUN: begin
          if (!stall) begin
            // id_pc tracks the fetch slot even when the instruction is squashed
            id_pc       <= pc;
            id_pc_plus4 <= pc_plus4;
            if (misaligned) begin
              id_inst     <= 32'h0;
              id_valid    <= 1'b0;
              fetch_fault <= 1'b1;
              state       <= FAULT;
            end else if (redirect) begin
              pc <= redirect_pc;
`ifdef FETCH_DELAY_SLOT_EN
              id_inst  <= imem_inst;
              id_valid <= 1'b1;
`else
              id_inst  <= 32'h0;
              id_valid <= 1'b0;
`endif
              state <= RUN;
            end else begin
              pc       <= pc_plus4;
              id_inst  <= imem_inst;
              id_valid <= 1'b1;
              state    <= RUN;
            end
          end
        end
        FAULT: begin
          id_inst  <= 32'h0;
          id_valid <= 1'b0;
        end
        default: begin
          state <= FAULT;
        end
      endcase
    end
  end

endmodule
